// File: rtl/wave_profile_gen.sv
// -----------------------------------------------------------------------------
// wave_profile_gen
//
// Builds a WIDTH-sample sine profile for a requested phase step and amplitude.
// The profile is written into a back buffer. When it is complete, the back
// buffer is swapped in as the current profile and the old current profile
// becomes the previous one. Display logic reads the current and previous
// profiles through one random-access port.
//
// Three RAM banks rotate between the current, previous and back roles. This
// lets both visible profiles stay readable while the next one is written.
//
// Ports
//   clock       system clock
//   reset       synchronous, active-high
//   frequency   phase step per sample (units of 2**-PHASE_W cycle)
//   amp         amplitude 0..16; larger values clamp to 16
//   new_f       request pulse; frequency/amp are sampled in the same cycle
//   busy        high while a request is queued or a profile is in progress
//   wave_ready  one-cycle pulse in the cycle the new profile is swapped in
//   rd_addr     sample index to read
//   rd_cur      current-profile sample at rd_addr (1-cycle latency, 0 if invalid)
//   rd_prev     previous-profile sample at rd_addr (1-cycle latency, 0 if invalid)
//   prev_valid  previous profile holds valid data
// -----------------------------------------------------------------------------
module wave_profile_gen #(
  parameter int LOG_WIDTH = 10,
  parameter int WIDTH     = 1024,
  parameter int RESOL     = 10,
  parameter int PHASE_W   = 16,
  parameter int AMP_W     = 5
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [PHASE_W-1:0]   frequency,
  input  logic [AMP_W-1:0]     amp,
  input  logic                 new_f,
  output logic                 busy,
  output logic                 wave_ready,
  input  logic [LOG_WIDTH-1:0] rd_addr,
  output logic [RESOL-1:0]     rd_cur,
  output logic [RESOL-1:0]     rd_prev,
  output logic                 prev_valid
);

  localparam int QW        = LOG_WIDTH - 2;      // offset bits within a quadrant
  localparam int QSIZE     = 2 ** QW;
  localparam int MAG_W     = RESOL - 1;          // magnitude bits of the signed sine
  localparam int PROD_W    = RESOL + AMP_W - 1;  // holds +/-(2**MAG_W-1)*16
  localparam int AMP_FULL  = 16;
  localparam int AMP_SHIFT = 4;

  localparam logic [LOG_WIDTH-1:0] LAST_IDX  = LOG_WIDTH'(WIDTH - 1);
  localparam logic [QW:0]          QTOP      = (QW + 1)'(QSIZE);
  localparam logic [AMP_W-1:0]     AMP_MAX   = AMP_W'(AMP_FULL);
  localparam logic [RESOL-1:0]     MID_VALUE = RESOL'(2 ** (RESOL - 1));

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] CALC  = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] SWAP  = 2'd3;

  // Quarter-wave entry k = round((2**MAG_W-1) * sin(k*pi/(2*QSIZE))), k = 0..QSIZE.
  // The table has QSIZE+1 entries so that the peak lands exactly on the
  // quadrant boundary. The sine is a fixed-point Taylor series scaled by 2**28,
  // which keeps the table constant-foldable without real arithmetic.
  function automatic int quarter_sine(input int k);
    longint scale;
    longint x;
    longint x2;
    longint term;
    longint sum;
    scale = 64'sd268435456;
    x     = (longint'(k) * 64'sd843314857) / longint'(2 * QSIZE);
    x2    = (x * x) / scale;
    term  = x;
    sum   = x;
    for (int n = 1; n < 10; n++) begin
      term = -((term * x2) / scale) / longint'((2 * n) * (2 * n + 1));
      sum  = sum + term;
    end
    return int'((longint'((2 ** MAG_W) - 1) * sum + scale / 2) / scale);
  endfunction

  logic [MAG_W-1:0] qrom [0:QSIZE];
  for (genvar gi = 0; gi <= QSIZE; gi++) begin : g_rom
    localparam logic [MAG_W-1:0] ENTRY = MAG_W'(quarter_sine(gi));
    assign qrom[gi] = ENTRY;
  end

  // Control state
  logic [1:0]           state_reg;
  logic                 drain_reg;
  logic                 pend_reg;
  logic [PHASE_W-1:0]   pend_freq_reg;
  logic [AMP_W-1:0]     pend_amp_reg;
  logic                 cur_valid_reg;
  logic                 prev_valid_reg;
  logic [1:0]           cur_bank_reg;
  logic [1:0]           prev_bank_reg;
  logic [1:0]           back_bank_reg;

  // Datapath
  logic [PHASE_W-1:0]   freq_reg;
  logic [AMP_W-1:0]     amp_reg;
  logic [PHASE_W-1:0]   phase_acc_reg;
  logic [LOG_WIDTH-1:0] idx_reg;
  logic                 s1_valid_reg;
  logic [LOG_WIDTH-1:0] s1_idx_reg;
  logic [LOG_WIDTH-1:0] s1_ptop_reg;
  logic                 s2_valid_reg;
  logic [LOG_WIDTH-1:0] s2_idx_reg;
  logic                 s2_neg_reg;
  logic [MAG_W-1:0]     s2_mag_reg;

  logic                 start;
  logic [AMP_W-1:0]     amp_clamped;
  logic [QW:0]          rom_addr;
  logic signed [PROD_W-1:0] sine_s;
  logic signed [PROD_W-1:0] amp_s;
  logic signed [PROD_W-1:0] prod_s;
  logic [RESOL-1:0]     wr_data;

  // A request is always staged in the pending slot first. It is launched from
  // IDLE, or straight from SWAP so that back-to-back profiles skip IDLE.
  assign start       = pend_reg && ((state_reg == IDLE) || (state_reg == SWAP));
  assign amp_clamped = (amp > AMP_MAX) ? AMP_MAX : amp;
  assign busy        = (state_reg != IDLE) || pend_reg;
  assign wave_ready  = (state_reg == SWAP);
  assign prev_valid  = prev_valid_reg;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg      <= IDLE;
      drain_reg      <= 1'b0;
      pend_reg       <= 1'b0;
      cur_valid_reg  <= 1'b0;
      prev_valid_reg <= 1'b0;
      cur_bank_reg   <= 2'd0;
      prev_bank_reg  <= 2'd1;
      back_bank_reg  <= 2'd2;
      s1_valid_reg   <= 1'b0;
      s2_valid_reg   <= 1'b0;
    end else begin
      // The newest request always wins. A request that arrives in the same
      // cycle one is launched stays queued behind it.
      if (new_f) begin
        pend_reg      <= 1'b1;
        pend_freq_reg <= frequency;
        pend_amp_reg  <= amp_clamped;
      end else if (start) begin
        pend_reg <= 1'b0;
      end

      s1_valid_reg <= (state_reg == CALC);
      s2_valid_reg <= s1_valid_reg;

      case (state_reg)
        IDLE: begin
          if (start) state_reg <= CALC;
        end
        CALC: begin
          if (idx_reg == LAST_IDX) begin
            state_reg <= DRAIN;
            drain_reg <= 1'b0;
          end
        end
        DRAIN: begin
          if (drain_reg) state_reg <= SWAP;
          else           drain_reg <= 1'b1;
        end
        SWAP: begin
          cur_bank_reg   <= back_bank_reg;
          prev_bank_reg  <= cur_bank_reg;
          back_bank_reg  <= prev_bank_reg;
          prev_valid_reg <= cur_valid_reg;
          cur_valid_reg  <= 1'b1;
          state_reg      <= start ? CALC : IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Quadrant folding: odd quadrants mirror the offset, the upper half negates.
  always_comb begin
    rom_addr = {1'b0, s1_ptop_reg[QW-1:0]};
    if (s1_ptop_reg[LOG_WIDTH-2]) begin
      rom_addr = QTOP - {1'b0, s1_ptop_reg[QW-1:0]};
    end
  end

  // Pipeline registers carry no reset. Their valid bits gate every write.
  always_ff @(posedge clock) begin
    if (start) begin
      freq_reg      <= pend_freq_reg;
      amp_reg       <= pend_amp_reg;
      phase_acc_reg <= '0;
      idx_reg       <= '0;
    end else if (state_reg == CALC) begin
      phase_acc_reg <= phase_acc_reg + freq_reg;
      idx_reg       <= idx_reg + 1'b1;
    end
    s1_idx_reg  <= idx_reg;
    s1_ptop_reg <= phase_acc_reg[PHASE_W-1 -: LOG_WIDTH];
    s2_idx_reg  <= s1_idx_reg;
    s2_neg_reg  <= s1_ptop_reg[LOG_WIDTH-1];
    s2_mag_reg  <= qrom[rom_addr];
  end

  // Signed scaling. The arithmetic shift floors negative products. The result
  // stays within [1, 2**RESOL-1], so it is safe to truncate to RESOL bits.
  always_comb begin
    sine_s  = s2_neg_reg ? -$signed(PROD_W'(s2_mag_reg)) : $signed(PROD_W'(s2_mag_reg));
    amp_s   = $signed(PROD_W'(amp_reg));
    prod_s  = sine_s * amp_s;
    wr_data = MID_VALUE + RESOL'(prod_s >>> AMP_SHIFT);
  end

  // Three banks, each with one write port and one registered read port.
  for (genvar gi = 0; gi < 3; gi++) begin : g_bank
    logic [RESOL-1:0] mem [0:WIDTH-1];
    logic [RESOL-1:0] rd_q;
    always_ff @(posedge clock) begin
      if (s2_valid_reg && (back_bank_reg == 2'(gi))) begin
        mem[s2_idx_reg] <= wr_data;
      end
      rd_q <= mem[rd_addr];
    end
  end

  // The bank roles and valid flags are registered alongside the read data.
  // A read issued during SWAP therefore still shows the pre-swap profiles.
  logic [1:0] cur_sel_q;
  logic [1:0] prev_sel_q;
  logic       cur_ok_q;
  logic       prev_ok_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      cur_ok_q   <= 1'b0;
      prev_ok_q  <= 1'b0;
      cur_sel_q  <= 2'd0;
      prev_sel_q <= 2'd1;
    end else begin
      cur_ok_q   <= cur_valid_reg;
      prev_ok_q  <= prev_valid_reg;
      cur_sel_q  <= cur_bank_reg;
      prev_sel_q <= prev_bank_reg;
    end
  end

  always_comb begin
    rd_cur  = '0;
    rd_prev = '0;
    if (cur_ok_q) begin
      case (cur_sel_q)
        2'd0:    rd_cur = g_bank[0].rd_q;
        2'd1:    rd_cur = g_bank[1].rd_q;
        2'd2:    rd_cur = g_bank[2].rd_q;
        default: rd_cur = '0;
      endcase
    end
    if (prev_ok_q) begin
      case (prev_sel_q)
        2'd0:    rd_prev = g_bank[0].rd_q;
        2'd1:    rd_prev = g_bank[1].rd_q;
        2'd2:    rd_prev = g_bank[2].rd_q;
        default: rd_prev = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_wave_profile_gen.sv
// -----------------------------------------------------------------------------
// tb_wave_profile_gen
//
// Directed bench for wave_profile_gen. The expected sample values are worked
// out by hand from sample = 512 + floor(s*amp/16), where
// s = +/- round(511*sin(k*pi/512)) is taken from the folded quarter-wave table.
//   k=0 -> 0,  k=1 -> 3,  k=16 -> 50,  k=64 -> 196,  k=128 -> 361,  k=256 -> 511
// -----------------------------------------------------------------------------
module tb_wave_profile_gen;

  logic        clock;
  logic        reset;
  logic [15:0] frequency;
  logic [4:0]  amp;
  logic        new_f;
  logic        busy;
  logic        wave_ready;
  logic [9:0]  rd_addr;
  logic [9:0]  rd_cur;
  logic [9:0]  rd_prev;
  logic        prev_valid;

  int checks = 0;
  int errors = 0;

  wave_profile_gen dut (
    .clock      (clock),
    .reset      (reset),
    .frequency  (frequency),
    .amp        (amp),
    .new_f      (new_f),
    .busy       (busy),
    .wave_ready (wave_ready),
    .rd_addr    (rd_addr),
    .rd_cur     (rd_cur),
    .rd_prev    (rd_prev),
    .prev_valid (prev_valid)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Pulse new_f for one cycle. Afterwards the bench sits in cycle 1 of the request.
  task automatic start_req(input logic [15:0] f, input logic [4:0] a);
    frequency = f;
    amp       = a;
    new_f     = 1'b1;
    step();
    new_f     = 1'b0;
    $display("request freq=%0d amp=%0d", f, a);
  endtask

  // Returns the cycle number, relative to the request, at which wave_ready is seen.
  task automatic wait_ready(output int n);
    n = 1;
    while (!wave_ready && n < 3000) begin
      step();
      n++;
    end
    $display("wave_ready seen at cycle %0d", n);
  endtask

  task automatic read_at(input logic [9:0] a, output logic [9:0] c, output logic [9:0] p);
    rd_addr = a;
    step();
    c = rd_cur;
    p = rd_prev;
    $display("read addr=%0d cur=%0d prev=%0d", a, c, p);
  endtask

  task automatic test_reset();
    logic [9:0] c, p;
    reset = 1'b1;
    repeat (3) step();
    reset = 1'b0;
    read_at(10'd5, c, p);
    checks++; if (c !== 10'd0) begin errors++; $display("FAIL reset_rd_cur got %0d exp 0", c); end
    checks++; if (p !== 10'd0) begin errors++; $display("FAIL reset_rd_prev got %0d exp 0", p); end
    checks++; if (prev_valid !== 1'b0) begin errors++; $display("FAIL reset_prev_valid got %b exp 0", prev_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (wave_ready !== 1'b0) begin errors++; $display("FAIL reset_wave_ready got %b exp 0", wave_ready); end
  endtask

  task automatic test_basic();
    int n;
    logic [9:0] c, p;
    start_req(16'd64, 5'd16);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy_c1 got %b exp 1", busy); end
    wait_ready(n);
    checks++; if (n != 1028) begin errors++; $display("FAIL basic_latency got %0d exp 1028", n); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy_c1028 got %b exp 1", busy); end
    step();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_after got %b exp 0", busy); end
    checks++; if (wave_ready !== 1'b0) begin errors++; $display("FAIL basic_ready_width got %b exp 0", wave_ready); end
    read_at(10'd0, c, p);
    checks++; if (c !== 10'd512) begin errors++; $display("FAIL basic_cur0 got %0d exp 512", c); end
    checks++; if (p !== 10'd0) begin errors++; $display("FAIL basic_prev0 got %0d exp 0", p); end
    read_at(10'd128, c, p);
    checks++; if (c !== 10'd873) begin errors++; $display("FAIL basic_cur128 got %0d exp 873", c); end
    read_at(10'd256, c, p);
    checks++; if (c !== 10'd1023) begin errors++; $display("FAIL basic_cur256 got %0d exp 1023", c); end
    read_at(10'd512, c, p);
    checks++; if (c !== 10'd512) begin errors++; $display("FAIL basic_cur512 got %0d exp 512", c); end
    read_at(10'd768, c, p);
    checks++; if (c !== 10'd1) begin errors++; $display("FAIL basic_cur768 got %0d exp 1", c); end
    checks++; if (prev_valid !== 1'b0) begin errors++; $display("FAIL basic_prev_valid got %b exp 0", prev_valid); end
  endtask

  task automatic test_double_buffer();
    int n;
    logic [9:0] c, p;
    start_req(16'd0, 5'd16);
    wait_ready(n);
    step();
    start_req(16'd64, 5'd8);
    wait_ready(n);
    checks++; if (n != 1028) begin errors++; $display("FAIL dbuf_latency got %0d exp 1028", n); end
    // A read issued in the SWAP cycle still returns the pre-swap buffers.
    read_at(10'd256, c, p);
    checks++; if (c !== 10'd512) begin errors++; $display("FAIL dbuf_swap_cur got %0d exp 512", c); end
    checks++; if (p !== 10'd1023) begin errors++; $display("FAIL dbuf_swap_prev got %0d exp 1023", p); end
    read_at(10'd256, c, p);
    checks++; if (c !== 10'd767) begin errors++; $display("FAIL dbuf_cur256 got %0d exp 767", c); end
    checks++; if (p !== 10'd512) begin errors++; $display("FAIL dbuf_prev256 got %0d exp 512", p); end
    read_at(10'd768, c, p);
    checks++; if (c !== 10'd256) begin errors++; $display("FAIL dbuf_cur768 got %0d exp 256", c); end
    checks++; if (p !== 10'd512) begin errors++; $display("FAIL dbuf_prev768 got %0d exp 512", p); end
    read_at(10'd0, c, p);
    checks++; if (p !== 10'd512) begin errors++; $display("FAIL dbuf_prev0 got %0d exp 512", p); end
    checks++; if (prev_valid !== 1'b1) begin errors++; $display("FAIL dbuf_prev_valid got %b exp 1", prev_valid); end
  endtask

  task automatic test_back_to_back();
    int pulses;
    int guard;
    int first_cyc;
    int second_cyc;
    logic [9:0] c, p;
    pulses     = 0;
    guard      = 0;
    first_cyc  = 0;
    second_cyc = 0;
    start_req(16'd128, 5'd16);
    repeat (10) step();
    start_req(16'd32, 5'd16);
    repeat (10) step();
    start_req(16'd64, 5'd16);
    while (busy && guard < 5000) begin
      step();
      guard++;
      if (wave_ready) begin
        pulses++;
        if (pulses == 1) first_cyc = guard;
        if (pulses == 2) second_cyc = guard;
      end
    end
    checks++; if (guard >= 5000) begin errors++; $display("FAIL b2b_timeout got %0d cycles exp <5000", guard); end
    checks++; if (pulses != 2) begin errors++; $display("FAIL b2b_pulses got %0d exp 2", pulses); end
    checks++; if (second_cyc - first_cyc != 1027) begin errors++; $display("FAIL b2b_gap got %0d exp 1027", second_cyc - first_cyc); end
    read_at(10'd128, c, p);
    checks++; if (c !== 10'd873) begin errors++; $display("FAIL b2b_cur128 got %0d exp 873", c); end
    checks++; if (p !== 10'd1023) begin errors++; $display("FAIL b2b_prev128 got %0d exp 1023", p); end
    read_at(10'd64, c, p);
    checks++; if (c !== 10'd708) begin errors++; $display("FAIL b2b_cur64 got %0d exp 708", c); end
    checks++; if (p !== 10'd873) begin errors++; $display("FAIL b2b_prev64 got %0d exp 873", p); end
  endtask

  task automatic test_wrap_clamp();
    int n;
    logic [9:0] c, p;
    start_req(16'd65535, 5'd20);
    wait_ready(n);
    step();
    read_at(10'd0, c, p);
    checks++; if (c !== 10'd512) begin errors++; $display("FAIL wrap_cur0 got %0d exp 512", c); end
    read_at(10'd1, c, p);
    checks++; if (c !== 10'd509) begin errors++; $display("FAIL wrap_cur1 got %0d exp 509", c); end
    read_at(10'd1000, c, p);
    checks++; if (c !== 10'd462) begin errors++; $display("FAIL wrap_cur1000 got %0d exp 462", c); end
  endtask

  task automatic test_reset_mid();
    int seen;
    int n;
    logic [9:0] c, p;
    seen = 0;
    start_req(16'd64, 5'd16);
    repeat (499) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got %b exp 0", busy); end
    for (int i = 0; i < 1100; i++) begin
      if (wave_ready) seen++;
      step();
    end
    checks++; if (seen != 0) begin errors++; $display("FAIL rst_mid_ready got %0d pulses exp 0", seen); end
    read_at(10'd256, c, p);
    checks++; if (c !== 10'd0) begin errors++; $display("FAIL rst_mid_cur got %0d exp 0", c); end
    checks++; if (p !== 10'd0) begin errors++; $display("FAIL rst_mid_prev got %0d exp 0", p); end
    checks++; if (prev_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_prev_valid got %b exp 0", prev_valid); end
    // The block must be fully usable again after the abort.
    start_req(16'd64, 5'd16);
    wait_ready(n);
    checks++; if (n != 1028) begin errors++; $display("FAIL rst_mid_relatency got %0d exp 1028", n); end
    step();
    read_at(10'd256, c, p);
    checks++; if (c !== 10'd1023) begin errors++; $display("FAIL rst_mid_cur256 got %0d exp 1023", c); end
    checks++; if (prev_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_prev_valid2 got %b exp 0", prev_valid); end
  endtask

  initial begin
    reset     = 1'b1;
    frequency = '0;
    amp       = '0;
    new_f     = 1'b0;
    rd_addr   = '0;
    test_reset();
    test_basic();
    test_double_buffer();
    test_back_to_back();
    test_wrap_clamp();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
